// File: rtl/btn_event_decoder_if.sv
// rtl/btn_event_decoder_if.sv - button level in, classified press events out
interface btn_event_decoder_if;
    logic i_btn;
    logic o_short_press;
    logic o_long_press;
    logic o_repeat;
    logic o_double_click;
    logic o_held;

    modport master (
        output i_btn,
        input  o_short_press, o_long_press, o_repeat, o_double_click, o_held
    );

    modport slave (
        input  i_btn,
        output o_short_press, o_long_press, o_repeat, o_double_click, o_held
    );
endinterface

// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - press classifier (short/long/repeat); double-click only with DOUBLE_CLICK_EN
module btn_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter int DCLICK_CYCLES = 25_000_000,
    parameter int CNT_W         = 27
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    btn_event_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD
`ifdef DOUBLE_CLICK_EN
        ,
        WAIT_SECOND,
        SECOND_PRESSED
`endif
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [CNT_W-1:0]  cnt_last;
    logic              r_prev;
    logic              rise;
    logic              term;
    logic              short_q, short_nx;
    logic              long_q, long_nx;
    logic              repeat_q, repeat_nx;
    logic              held_q, held_nx;

    assign rise = bus.i_btn & ~r_prev;

    // One shared counter; the terminal value depends on which interval is being timed.
    always_comb begin
        cnt_last = DCLICK_LAST;
        case (state)
            PRESSED:   cnt_last = LONG_LAST;
            LONG_HELD: cnt_last = REPEAT_LAST;
            default:   cnt_last = DCLICK_LAST;
        endcase
    end

    assign term = (cnt == cnt_last);

`ifdef DOUBLE_CLICK_EN
    logic dclick_q, dclick_nx;
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        repeat_nx = 1'b0;
        held_nx   = 1'b0;
`ifdef DOUBLE_CLICK_EN
        dclick_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end
            end
            PRESSED: begin
                held_nx = bus.i_btn;
                // Release is checked first so a release on the terminal count stays a short press.
                if (!bus.i_btn) begin
                    cnt_nx = '0;
`ifdef DOUBLE_CLICK_EN
                    state_nx = WAIT_SECOND;
`else
                    short_nx = 1'b1;
                    state_nx = IDLE;
`endif
                end else if (term) begin
                    long_nx  = 1'b1;
                    state_nx = LONG_HELD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                held_nx = bus.i_btn;
                if (!bus.i_btn) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (term) begin
                    repeat_nx = 1'b1;
                    cnt_nx    = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`ifdef DOUBLE_CLICK_EN
            WAIT_SECOND: begin
                if (rise) begin
                    state_nx = SECOND_PRESSED;
                    cnt_nx   = '0;
                end else if (term) begin
                    short_nx = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SECOND_PRESSED: begin
                held_nx = bus.i_btn;
                if (!bus.i_btn) begin
                    dclick_nx = 1'b1;
                    state_nx  = IDLE;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // r_prev resets high so a button held through reset must be released before it counts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            r_prev   <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            r_prev   <= bus.i_btn;
            short_q  <= short_nx;
            long_q   <= long_nx;
            repeat_q <= repeat_nx;
            held_q   <= held_nx;
        end
    end

`ifdef DOUBLE_CLICK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dclick_q <= 1'b0;
        end else begin
            dclick_q <= dclick_nx;
        end
    end

    assign bus.o_double_click = dclick_q;
`else
    assign bus.o_double_click = 1'b0;
`endif

    assign bus.o_short_press = short_q;
    assign bus.o_long_press  = long_q;
    assign bus.o_repeat      = repeat_q;
    assign bus.o_held        = held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - randomized and directed checks against a run-length press model
module tb_btn_event_decoder;

    localparam int LONG = 8;
    localparam int REP  = 4;
    localparam int DCL  = 6;
    localparam int MAXN = 1024;
    localparam int T0   = 2;
`ifdef DOUBLE_CLICK_EN
    localparam int SHORT_EXTRA = DCL;
`else
    localparam int SHORT_EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btn_event_decoder_if bus();

    btn_event_decoder #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP),
        .DCLICK_CYCLES (DCL),
        .CNT_W         (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Event vector bits: 0 short, 1 long, 2 repeat, 3 double-click, 4 held.
    bit         stim [MAXN];
    logic [4:0] obs  [MAXN];
    logic [4:0] expv [MAXN];
    int         n;
    int         checks = 0;
    int         passes = 0;

    function automatic logic [4:0] sample();
        return {bus.o_held, bus.o_double_click, bus.o_repeat, bus.o_long_press, bus.o_short_press};
    endfunction

    function automatic void mark(input int idx, input int b, input int hi);
        if (idx < hi) expv[idx][b] = 1'b1;
    endfunction

    // Walks the stimulus press by press: each high run is classified by its length,
    // and each event lands at a cycle computed from where the run starts and ends.
    function automatic void model(input int lo, input int hi);
        int i;
        int t;
        int len;
        i = lo;
        while (i < hi) begin
            t = -1;
            len = 0;
            for (int k = i; k < hi; k++)
                if (t < 0 && k > lo && stim[k] && !stim[k-1]) t = k;
            if (t < 0) break;
            while (t + len < hi && stim[t+len]) len++;
            for (int k = t + 2; k <= t + len; k++) mark(k, 4, hi);
            if (len > LONG) begin
                mark(t + LONG + 1, 1, hi);
                for (int c = t + LONG + 1 + REP; c <= t + len; c += REP) mark(c, 2, hi);
                i = t + len + 1;
            end else begin
`ifdef DOUBLE_CLICK_EN
                int s;
                int len2;
                s = -1;
                len2 = 0;
                for (int k = t + len + 1; k <= t + len + DCL && k < hi; k++)
                    if (s < 0 && stim[k] && !stim[k-1]) s = k;
                if (s < 0) begin
                    mark(t + len + DCL + 1, 0, hi);
                    i = t + len + DCL + 1;
                end else begin
                    while (s + len2 < hi && stim[s+len2]) len2++;
                    for (int k = s + 2; k <= s + len2; k++) mark(k, 4, hi);
                    mark(s + len2 + 1, 3, hi);
                    i = s + len2 + 1;
                end
`else
                mark(t + len + 1, 0, hi);
                i = t + len + 1;
`endif
            end
        end
    endfunction

    function automatic void prep(input int rst_at);
        for (int k = 0; k < n; k++) expv[k] = '0;
        if (rst_at < 0) begin
            model(0, n);
        end else begin
            model(0, rst_at);
            model(rst_at + 1, n);
        end
    endfunction

    task automatic add(input bit v, input int cnt);
        for (int k = 0; k < cnt && n < MAXN; k++) begin
            stim[n] = v;
            n++;
        end
    endtask

    task automatic play(input bit init_btn, input int rst_at);
        rst_n = 1'b0;
        bus.i_btn = init_btn;
        repeat (3) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            rst_n = (k == rst_at) ? 1'b0 : 1'b1;
            bus.i_btn = stim[k];
            #1 obs[k] = sample();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n = 0;
        add(1'b1, 20);
        add(1'b0, 10);
        prep(-1);
        play(1'b1, -1);
        checks++;
        if (obs[0] !== 5'b0) $display("FAIL reset_state: got %b expected 00000", obs[0]);
        else passes++;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL reset_held cycle %0d: got %b expected %b", k, obs[k], expv[k]);
            else passes++;
        end
    endtask

    task automatic test_short();
        n = 0;
        add(1'b0, T0);
        add(1'b1, 3);
        add(1'b0, 20);
        prep(-1);
        play(1'b0, -1);
        checks++;
        if (obs[T0+4+SHORT_EXTRA][0] !== 1'b1)
            $display("FAIL short_pulse: got %b expected 1", obs[T0+4+SHORT_EXTRA][0]);
        else passes++;
        checks++;
        if ({obs[T0+4][4], obs[T0+3][4], obs[T0+2][4], obs[T0+1][4]} !== 4'b0110)
            $display("FAIL short_held: got %b expected 0110",
                     {obs[T0+4][4], obs[T0+3][4], obs[T0+2][4], obs[T0+1][4]});
        else passes++;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL short cycle %0d: got %b expected %b", k, obs[k], expv[k]);
            else passes++;
        end
    endtask

    task automatic test_long();
        int reps;
        int shorts;
        n = 0;
        add(1'b0, T0);
        add(1'b1, 20);
        add(1'b0, 20);
        prep(-1);
        play(1'b0, -1);
        reps = 0;
        shorts = 0;
        for (int k = 0; k < n; k++) begin
            reps += int'(obs[k][2]);
            shorts += int'(obs[k][0]);
        end
        checks++;
        if (obs[T0+9][1] !== 1'b1) $display("FAIL long_pulse: got %b expected 1", obs[T0+9][1]);
        else passes++;
        checks++;
        if ({obs[T0+17][2], obs[T0+13][2]} !== 2'b11 || reps != 2)
            $display("FAIL long_repeat: got %0d repeats expected 2 at +13/+17", reps);
        else passes++;
        checks++;
        if (shorts != 0) $display("FAIL long_no_short: got %0d expected 0", shorts);
        else passes++;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL long cycle %0d: got %b expected %b", k, obs[k], expv[k]);
            else passes++;
        end
    endtask

    task automatic test_terminal();
        int longs;
        n = 0;
        add(1'b0, T0);
        add(1'b1, LONG);
        add(1'b0, 20);
        prep(-1);
        play(1'b0, -1);
        longs = 0;
        for (int k = 0; k < n; k++) longs += int'(obs[k][1]);
        checks++;
        if (obs[T0+9+SHORT_EXTRA][0] !== 1'b1)
            $display("FAIL terminal_short: got %b expected 1", obs[T0+9+SHORT_EXTRA][0]);
        else passes++;
        checks++;
        if (longs != 0) $display("FAIL terminal_no_long: got %0d expected 0", longs);
        else passes++;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL terminal cycle %0d: got %b expected %b", k, obs[k], expv[k]);
            else passes++;
        end
    endtask

    task automatic test_double_click();
        int shorts;
        n = 0;
        add(1'b0, T0);
        add(1'b1, 3);
        add(1'b0, 2);
        add(1'b1, 3);
        add(1'b0, 20);
        prep(-1);
        play(1'b0, -1);
        shorts = 0;
        for (int k = 0; k < n; k++) shorts += int'(obs[k][0]);
        checks++;
`ifdef DOUBLE_CLICK_EN
        if (obs[T0+9][3] !== 1'b1 || shorts != 0)
            $display("FAIL dclick_pulse: got dclick=%b shorts=%0d expected 1 and 0", obs[T0+9][3], shorts);
        else passes++;
`else
        if (shorts != 2 || obs[T0+9][3] !== 1'b0)
            $display("FAIL dclick_off: got shorts=%0d dclick=%b expected 2 and 0", shorts, obs[T0+9][3]);
        else passes++;
`endif
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL dclick cycle %0d: got %b expected %b", k, obs[k], expv[k]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_press();
        int pulses;
        int r;
        n = 0;
        add(1'b0, T0);
`ifdef DOUBLE_CLICK_EN
        add(1'b1, 3);
        r = T0 + 6;
`else
        add(1'b1, 10);
        r = T0 + 4;
`endif
        add(1'b0, 25);
        prep(r);
        play(1'b0, r);
        pulses = 0;
        for (int k = 0; k < n; k++) pulses += int'(obs[k][0]) + int'(obs[k][1]) + int'(obs[k][2]) + int'(obs[k][3]);
        checks++;
        if (pulses != 0) $display("FAIL reset_mid_press: got %0d pulses expected 0", pulses);
        else passes++;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) $display("FAIL midreset cycle %0d: got %b expected %b", k, obs[k], expv[k]);
            else passes++;
        end
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 6; it++) begin
            n = 0;
            while (n < 350) begin
                add(1'b0, int'($urandom_range(1, 10)));
                add(1'b1, int'($urandom_range(1, 24)));
            end
            add(1'b0, 30);
            r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 330)) : -1;
            prep(r);
            play(1'($urandom_range(0, 1)), r);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (obs[k] !== expv[k])
                    $display("FAIL random%0d cycle %0d: got %b expected %b", it, k, obs[k], expv[k]);
                else passes++;
            end
        end
    endtask

    initial begin
        bus.i_btn = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_terminal();
        test_double_click();
        test_reset_mid_press();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
